// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the synchronous data memory.
// Optional burst lock is compiled in when DMEM_ARB_LOCK_EN is defined.
module dmem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int FIXED_PRI  = 0,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT0,
    S_GNT1,
    S_LOCK0,
    S_LOCK1
  } state_t;

  state_t        state;
  logic          rr_last;
  logic [SW-1:0] starve_cnt;
  logic [3:0]    lock_cnt;

  logic p1_v, p1_port;
  logic p2_v, p2_port;

  logic el0, el1;
  logic lk0, lk1;
  logic hold0, hold1;
  logic pick1;
  logic win0, win1;
  logic ld;

  always_comb begin
    lk0   = 1'b0;
    lk1   = 1'b0;
    hold0 = 1'b0;
    hold1 = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    lk0   = lock0;
    lk1   = lock1;
    hold0 = (state == S_LOCK0) && req0 && lock0
            && (lock_cnt < 4'd8);
    hold1 = (state == S_LOCK1) && req1 && lock1
            && (lock_cnt < 4'd8);
`endif
    el0   = req0 && !gnt0;
    el1   = req1 && !gnt1;
    // pick1 decides a tie between two eligible requests
    pick1 = (FIXED_PRI != 0)
            ? (starve_cnt == SW'(STARVE_LIM))
            : !rr_last;
    win0  = hold0 || (!hold1 && el0 && !(el1 && pick1));
    win1  = hold1 || (!hold0 && el1 && !(el0 && !pick1));
    ld    = win0 ? !we0 : (win1 && !we1);
  end

`ifndef DMEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = ^{lock0, lock1, state, lock_cnt};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      rr_last    <= 1'b1;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      p1_v       <= 1'b0;
      p1_port    <= 1'b0;
      p2_v       <= 1'b0;
      p2_port    <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      gnt0   <= win0;
      gnt1   <= win1;
      mem_en <= win0 | win1;
      mem_we <= win0 ? we0 : (win1 & we1);
      if (win0) begin
        mem_addr  <= addr0;
        mem_wdata <= wdata0;
      end else if (win1) begin
        mem_addr  <= addr1;
        mem_wdata <= wdata1;
      end
      if (win0 | win1)
        rr_last <= win1;

      if (win1 || !req1)
        starve_cnt <= '0;
      else if (el1 && starve_cnt != SW'(STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);

      unique case (1'b1)
        hold0 | hold1: begin
          lock_cnt <= lock_cnt + 4'd1;
        end
        win0 & ~hold0: begin
          state    <= lk0 ? S_LOCK0 : S_GNT0;
          lock_cnt <= 4'd1;
        end
        win1 & ~hold1: begin
          state    <= lk1 ? S_LOCK1 : S_GNT1;
          lock_cnt <= 4'd1;
        end
        default: begin
          state    <= S_IDLE;
          lock_cnt <= '0;
        end
      endcase

      // load return pipe: grant edge, memory sample edge, capture edge
      p1_v    <= ld;
      p1_port <= win1;
      p2_v    <= p1_v;
      p2_port <= p1_port;
      rvalid0 <= p2_v & ~p2_port;
      rvalid1 <= p2_v & p2_port;
      if (p2_v & ~p2_port)
        rdata0 <= mem_rdata;
      if (p2_v & p2_port)
        rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: round-robin and fixed-priority instances
// driven side by side and compared against a behavioural model.
module tb_dmem_port_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0[2], req1[2], we0[2], we1[2];
  logic          lock0[2], lock1[2];
  logic [AW-1:0] addr0[2], addr1[2];
  logic [DW-1:0] wdata0[2], wdata1[2];
  logic          gnt0[2], gnt1[2], rvalid0[2], rvalid1[2];
  logic          mem_en[2], mem_we[2];
  logic [DW-1:0] rdata0[2], rdata1[2];
  logic [DW-1:0] mem_wdata[2], mem_rdata[2];
  logic [AW-1:0] mem_addr[2];

  logic [DW-1:0] mem[2][0:65535];
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [DW-1:0] pre_data = '0;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] pool[8] = '{16'h0000, 16'h0010, 16'h0011, 16'h1234,
                             16'h8000, 16'hFFFE, 16'hFFFF, 16'h0042};

  dmem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(0), .STARVE_LIM(LIM)) u_rr (
    .clk(clk), .reset(reset),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .addr0(addr0[0]), .addr1(addr1[0]),
    .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .lock0(lock0[0]), .lock1(lock1[0]),
    .gnt0(gnt0[0]), .gnt1(gnt1[0]),
    .rvalid0(rvalid0[0]), .rvalid1(rvalid1[0]),
    .rdata0(rdata0[0]), .rdata1(rdata1[0]),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0])
  );

  dmem_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRI(1), .STARVE_LIM(LIM)) u_fp (
    .clk(clk), .reset(reset),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .addr0(addr0[1]), .addr1(addr1[1]),
    .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .lock0(lock0[1]), .lock1(lock1[1]),
    .gnt0(gnt0[1]), .gnt1(gnt1[1]),
    .rvalid0(rvalid0[1]), .rvalid1(rvalid1[1]),
    .rdata0(rdata0[1]), .rdata1(rdata1[1]),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1])
  );

  // synchronous-read memory arrays, one per instance
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (pre_we)
        mem[k][pre_addr] <= pre_data;
      else if (mem_en[k] && mem_we[k])
        mem[k][mem_addr[k]] <= mem_wdata[k];
      if (mem_en[k] && !mem_we[k])
        mem_rdata[k] <= mem[k][mem_addr[k]];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            k;
    int            due;
    int            port;
    logic [DW-1:0] data;
  } ret_t;

  ret_t          rq[$];
  int            cyc = 0;
  logic          m_g0[2], m_g1[2], m_en[2], m_we[2], m_rv0[2], m_rv1[2];
  logic [AW-1:0] m_addr[2];
  logic [DW-1:0] m_wd[2], m_rd0[2], m_rd1[2];
  int            m_rr[2], m_st[2], m_lk[2], m_lp[2], m_ln[2];
  logic [DW-1:0] shadow[2][0:65535];

  task automatic model_step();
    ret_t keep[$];
    cyc++;
    for (int k = 0; k < 2; k++) begin
      int win;
      bit e0, e1, hold;
      if (!reset) begin
        m_g0[k] = 0; m_g1[k] = 0; m_en[k] = 0; m_we[k] = 0;
        m_addr[k] = '0; m_wd[k] = '0; m_rd0[k] = '0; m_rd1[k] = '0;
        m_rr[k] = 1; m_st[k] = 0; m_lk[k] = 0; m_ln[k] = 0;
        continue;
      end
      win  = -1;
      hold = 0;
`ifdef DMEM_ARB_LOCK_EN
      if (m_lk[k] != 0 && m_ln[k] < 8 &&
          (m_lp[k] == 0 ? (req0[k] && lock0[k]) : (req1[k] && lock1[k]))) begin
        hold = 1;
        win  = m_lp[k];
      end
`endif
      e0 = req0[k] && !m_g0[k];
      e1 = req1[k] && !m_g1[k];
      if (!hold) begin
        if (e0 && e1) begin
          if (k == 1) win = (m_st[k] >= LIM) ? 1 : 0;
          else        win = (m_rr[k] == 0) ? 1 : 0;
        end else if (e0) win = 0;
        else if (e1)     win = 1;
      end
      if (win == 1 || !req1[k]) m_st[k] = 0;
      else if (e1 && m_st[k] < LIM) m_st[k]++;
      m_g0[k] = (win == 0);
      m_g1[k] = (win == 1);
      m_en[k] = (win >= 0);
      m_we[k] = 0;
      if (win >= 0) begin
        m_rr[k]   = win;
        m_we[k]   = (win == 0) ? we0[k] : we1[k];
        m_addr[k] = (win == 0) ? addr0[k] : addr1[k];
        m_wd[k]   = (win == 0) ? wdata0[k] : wdata1[k];
        if (m_we[k]) shadow[k][m_addr[k]] = m_wd[k];
        else rq.push_back('{k, cyc + 2, win, shadow[k][m_addr[k]]});
        if (hold) m_ln[k]++;
        else begin
          m_lk[k] = 0;
`ifdef DMEM_ARB_LOCK_EN
          if ((win == 0) ? lock0[k] : lock1[k]) begin
            m_lk[k] = 1; m_lp[k] = win; m_ln[k] = 1;
          end
`endif
        end
      end else m_lk[k] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      m_rv0[k] = 0;
      m_rv1[k] = 0;
    end
    foreach (rq[i]) begin
      if (!reset) continue;
      if (rq[i].due == cyc) begin
        if (rq[i].port == 0) begin
          m_rv0[rq[i].k] = 1; m_rd0[rq[i].k] = rq[i].data;
        end else begin
          m_rv1[rq[i].k] = 1; m_rd1[rq[i].k] = rq[i].data;
        end
      end else keep.push_back(rq[i]);
    end
    rq = keep;
  endtask

  task automatic advance();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      req0[k] = 0; req1[k] = 0; we0[k] = 0; we1[k] = 0;
      lock0[k] = 0; lock1[k] = 0;
      addr0[k] = '0; addr1[k] = '0; wdata0[k] = '0; wdata1[k] = '0;
    end
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    advance();
    advance();
    reset = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    for (int k = 0; k < 2; k++) req0[k] = 1;
    for (int i = 0; i < 8; i++) begin
      pre_we   = 1;
      pre_addr = pool[i];
      pre_data = (pool[i] == 16'h0010) ? 16'hBEEF : 16'($urandom);
      shadow[0][pool[i]] = pre_data;
      shadow[1][pool[i]] = pre_data;
      advance();
    end
    pre_we = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], mem_en[k], mem_we[k]} !== 6'b0) begin
        errors++;
        $display("FAIL reset_ctl k=%0d got=%b%b%b%b%b%b want=000000", k,
                 gnt0[k], gnt1[k], rvalid0[k], rvalid1[k], mem_en[k], mem_we[k]);
      end
      checks++;
      if ({mem_addr[k], mem_wdata[k], rdata0[k], rdata1[k]} !== 64'h0) begin
        errors++;
        $display("FAIL reset_data k=%0d got=%h %h %h %h want=0", k,
                 mem_addr[k], mem_wdata[k], rdata0[k], rdata1[k]);
      end
    end
    reset = 1;
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt0[k], gnt1[k], mem_en[k]} !== 3'b101) begin
        errors++;
        $display("FAIL reset_release k=%0d got gnt0/gnt1/en=%b%b%b want=101", k,
                 gnt0[k], gnt1[k], mem_en[k]);
      end
    end
  endtask

  task automatic test_load();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1; we0[k] = 0; addr0[k] = 16'h0010;
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt0[k], mem_en[k], mem_we[k], mem_addr[k]} !== {3'b110, 16'h0010}) begin
        errors++;
        $display("FAIL load_grant k=%0d got g/en/we=%b%b%b addr=%h want 110 0010", k,
                 gnt0[k], mem_en[k], mem_we[k], mem_addr[k]);
      end
      req0[k] = 0;
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt0[k], rvalid0[k]} !== 2'b00) begin
        errors++;
        $display("FAIL load_e2 k=%0d got gnt0=%b rvalid0=%b want 0 0", k, gnt0[k], rvalid0[k]);
      end
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rvalid0[k] !== 1'b1 || rdata0[k] !== 16'hBEEF) begin
        errors++;
        $display("FAIL load_ret k=%0d got rvalid0=%b rdata0=%h want 1 beef", k,
                 rvalid0[k], rdata0[k]);
      end
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rvalid0[k] !== 1'b0 || rvalid1[k] !== 1'b0) begin
        errors++;
        $display("FAIL load_pulse k=%0d got rvalid0=%b rvalid1=%b want 0 0", k,
                 rvalid0[k], rvalid1[k]);
      end
    end
  endtask

  task automatic test_alternate();
    int n0[2], n1[2];
    logic [AW-1:0] a0[2], a1[2];
    do_reset();
    for (int k = 0; k < 2; k++) begin
      n0[k] = 0; n1[k] = 0;
      req0[k] = 1; we0[k] = 1; addr0[k] = 16'h0100; wdata0[k] = 16'h0100 ^ 16'hA5A5;
      req1[k] = 1; we1[k] = 1; addr1[k] = 16'h0200; wdata1[k] = 16'h0200 ^ 16'hA5A5;
    end
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin a0[k] = addr0[k]; a1[k] = addr1[k]; end
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({gnt0[k], gnt1[k], mem_en[k]} !== {(i % 2 == 0), (i % 2 == 1), 1'b1} ||
            mem_addr[k] !== ((i % 2 == 0) ? a0[k] : a1[k])) begin
          errors++;
          $display("FAIL alternate k=%0d edge=%0d got g0/g1/en=%b%b%b addr=%h want %0d %0d 1 addr=%h",
                   k, i, gnt0[k], gnt1[k], mem_en[k], mem_addr[k],
                   (i % 2 == 0), (i % 2 == 1), (i % 2 == 0) ? a0[k] : a1[k]);
        end
        if (m_g0[k]) begin
          n0[k]++; addr0[k] = 16'h0100 + 16'(n0[k]); wdata0[k] = addr0[k] ^ 16'hA5A5;
        end
        if (m_g1[k]) begin
          n1[k]++; addr1[k] = 16'h0200 + 16'(n1[k]); wdata1[k] = addr1[k] ^ 16'hA5A5;
        end
      end
    end
    clear_inputs();
    advance();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 3; j++) begin
        logic [AW-1:0] x, y;
        x = 16'h0100 + 16'(j);
        y = 16'h0200 + 16'(j);
        checks++;
        if (mem[k][x] !== (x ^ 16'hA5A5) || mem[k][y] !== (y ^ 16'hA5A5)) begin
          errors++;
          $display("FAIL alt_written k=%0d j=%0d got %h %h want %h %h", k, j,
                   mem[k][x], mem[k][y], x ^ 16'hA5A5, y ^ 16'hA5A5);
        end
      end
    end
  endtask

  task automatic test_starve();
    int got;
    do_reset();
    req0[1] = 1; we0[1] = 1; addr0[1] = 16'h0300;
    req1[1] = 1; we1[1] = 1; addr1[1] = 16'h0400;
    got = 0;
    for (int i = 1; i <= 8 && got == 0; i++) begin
      advance();
      if (i == 1) begin
        checks++;
        if (u_fp.starve_cnt !== 3'd1) begin
          errors++;
          $display("FAIL starve_count got=%0d want=1", u_fp.starve_cnt);
        end
      end
      if (m_g0[1]) addr0[1] = addr0[1] + 16'd1;
      if (gnt1[1] === 1'b1) got = i;
    end
    checks++;
    if (got < 1 || got > 5) begin
      errors++;
      $display("FAIL starve_bound got grant edge=%0d want 1..5", got);
    end
    checks++;
    if (u_fp.starve_cnt !== 3'd0) begin
      errors++;
      $display("FAIL starve_clear got=%0d want=0", u_fp.starve_cnt);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1; we0[k] = 0; addr0[k] = 16'h0011;
    end
    advance();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (gnt0[k] !== 1'b1) begin
        errors++;
        $display("FAIL mid_grant k=%0d got=%b want=1", k, gnt0[k]);
      end
      req0[k] = 0;
    end
    reset = 0;
    advance();
    reset = 1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mem_en[k] !== 1'b0 || gnt0[k] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset k=%0d got en=%b gnt0=%b want 0 0", k, mem_en[k], gnt0[k]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (rvalid0[k] !== 1'b0) begin
          errors++;
          $display("FAIL mid_drop k=%0d edge=%0d got rvalid0=%b want 0", k, i, rvalid0[k]);
        end
      end
    end
  endtask

  task automatic test_lock();
    logic [9:0] eg0, eg1;
`ifdef DMEM_ARB_LOCK_EN
    eg0 = 10'b1011111111;
    eg1 = 10'b0100000000;
`else
    eg0 = 10'b0101010101;
    eg1 = 10'b1010101010;
`endif
    do_reset();
    for (int k = 0; k < 2; k++) begin
      req0[k] = 1; lock0[k] = 1; we0[k] = 1; addr0[k] = 16'h0500;
      req1[k] = 1; we1[k] = 1; addr1[k] = 16'h0600;
    end
    for (int i = 0; i < 10; i++) begin
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (gnt0[k] !== eg0[i] || gnt1[k] !== eg1[i]) begin
          errors++;
          $display("FAIL lock_seq k=%0d edge=%0d got g0=%b g1=%b want %b %b", k, i,
                   gnt0[k], gnt1[k], eg0[i], eg1[i]);
        end
      end
    end
  endtask

  task automatic rand_inputs(int k);
    if (!req0[k] || m_g0[k]) begin
      req0[k]   = ($urandom_range(0, 3) != 0);
      we0[k]    = 1'($urandom_range(0, 1));
      addr0[k]  = pool[$urandom_range(0, 7)];
      wdata0[k] = 16'($urandom);
    end
    if (!req1[k] || m_g1[k]) begin
      req1[k]   = ($urandom_range(0, 3) != 0);
      we1[k]    = 1'($urandom_range(0, 1));
      addr1[k]  = pool[$urandom_range(0, 7)];
      wdata1[k] = 16'($urandom);
    end
    lock0[k] = ($urandom_range(0, 3) != 0);
    lock1[k] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 63) != 0);
      rand_inputs(0);
      rand_inputs(1);
      advance();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({gnt0[k], gnt1[k], mem_en[k], mem_we[k], rvalid0[k], rvalid1[k]} !==
            {m_g0[k], m_g1[k], m_en[k], m_we[k], m_rv0[k], m_rv1[k]}) begin
          errors++;
          $display("FAIL rand_ctl k=%0d n=%0d got=%b%b%b%b%b%b want=%b%b%b%b%b%b", k, n,
                   gnt0[k], gnt1[k], mem_en[k], mem_we[k], rvalid0[k], rvalid1[k],
                   m_g0[k], m_g1[k], m_en[k], m_we[k], m_rv0[k], m_rv1[k]);
        end
        checks++;
        if (mem_addr[k] !== m_addr[k] || mem_wdata[k] !== m_wd[k]) begin
          errors++;
          $display("FAIL rand_bus k=%0d n=%0d got %h/%h want %h/%h", k, n,
                   mem_addr[k], mem_wdata[k], m_addr[k], m_wd[k]);
        end
        if (m_rv0[k] || m_rv1[k]) begin
          checks++;
          if ((m_rv0[k] && rdata0[k] !== m_rd0[k]) ||
              (m_rv1[k] && rdata1[k] !== m_rd1[k])) begin
            errors++;
            $display("FAIL rand_rdata k=%0d n=%0d got %h/%h want %h/%h", k, n,
                     rdata0[k], rdata1[k], m_rd0[k], m_rd1[k]);
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_load();
    test_alternate();
    test_starve();
    test_reset_midflight();
    test_lock();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline load/store stage, port 1 is the Qat/loader side.
- Arbitration is round-robin or fixed-priority with a starvation guard. Memory-side outputs, grants and read returns are all registered.
- Sits between the processor's memory stage and the `DMEM_SIZE` data memory array, which reads synchronously.

Parameters:
- AW, 16, address width (the data memory is 2**AW words).
- DW, 16, data word width (`WORD_SIZE`).
- FIXED_PRI, 0, arbitration mode. 0 = round-robin; 1 = port 0 has priority.
- STARVE_LIM, 4, used only when FIXED_PRI=1. After a pending port-1 request has lost this many consecutive arbitration edges, port 1 wins the next one.

Ports:
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-low; sampled on posedge clk, reset==0 resets.
- req0/req1  in  1  access request; held high until the matching gnt is seen.
- we0/we1  in  1  1 = store, 0 = load; qualified by req.
- addr0/addr1  in  AW  word address.
- wdata0/wdata1  in  DW  store data.
- lock0/lock1  in  1  burst lock request; ignored unless DMEM_ARB_LOCK_EN is defined.
- gnt0/gnt1  out  1  one-cycle pulse: request accepted.
- rvalid0/rvalid1  out  1  one-cycle pulse: load data valid.
- rdata0/rdata1  out  DW  load data, meaningful only while the matching rvalid is high.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, valid the cycle after the edge that sampled mem_en=1 with mem_we=0.

Behaviour:
- Reset values: every output is 0; FSM = S_IDLE; rr_last = 1 (so port 0 wins the first tie); starve_cnt = 0; the read pipeline is cleared.
- Reset asserted mid-operation: in-flight loads are dropped and no rvalid is issued for them.
- Eligibility at each edge: reqX counts only if gntX is currently low, so a request is never granted twice.
  - Exception: the lock feature, described below.
- FSM states:
  - S_IDLE → S_GNT0 or S_GNT1 when an eligible request wins.
  - S_GNTx → S_GNTy if another request wins on this edge, else S_IDLE.
  - S_LOCKx is reachable only with the lock feature.
- On a win, in the same edge:
  - gntX <= 1;
  - mem_en <= 1, mem_we <= weX, mem_addr <= addrX, mem_wdata <= wdataX;
  - port id and load flag are pushed into a 2-stage return pipe.
- With no win: gnt0 = gnt1 = mem_en = mem_we = 0. mem_addr and mem_wdata hold their values.
- Round-robin (FIXED_PRI=0):
  - Exactly one eligible request wins.
  - When both are eligible, the port != rr_last wins; rr_last <= the winner.
- Fixed priority (FIXED_PRI=1):
  - Port 0 wins ties.
  - starve_cnt increments on each edge where req1 is eligible and loses; it saturates at STARVE_LIM.
  - When starve_cnt == STARVE_LIM, port 1 wins the next tie; starve_cnt clears whenever port 1 is granted or req1 is low.
- Load latency:
  - Edge E1 grants (mem_en high after E1).
  - The memory samples at E2.
  - mem_rdata is registered into rdataX at E3, and rvalidX is high for the cycle after E3.
  - Loads are therefore fully pipelined, one per cycle.
- Stores produce no rvalid.
- Back-to-back alternating grants are legal: 0,1,0,1 gives full memory bandwidth. The same port without lock gets at most one grant every 2 cycles.
- Two returns never collide: the return pipe is ordered, and each stage belongs to exactly one port.
- Address wrap: addresses are used unmodified, so 2**AW-1 is legal and there is no wrap logic.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- When defined:
  - If port X is granted with lockX=1, the FSM enters S_LOCKX.
  - In S_LOCKX, reqX is eligible even while gntX is high, so port X may issue one access per cycle. The other port is never granted.
  - The lock releases (→ S_IDLE, or → S_GNTy if the other port wins) on the first edge where reqX=0 or lockX=0.
  - The lock also releases after 8 consecutive locked grants; a hard cap of 8 prevents lockout.
- When undefined: lock0/lock1 are ignored, S_LOCKx is never entered, and behaviour is exactly as above.

Test Plan:
- Reset with reset=0 for 2 edges while req0=1 → all outputs 0, no gnt. Release → gnt0 pulses on the first edge.
- Load: req0=1, we0=0, addr0=16'h0010, memory[16'h0010]=16'hBEEF → gnt0 in cycle after E1, mem_addr=16'h0010; rvalid0=1 with rdata0=16'hBEEF in cycle after E3, for exactly 1 cycle.
- FIXED_PRI=0, req0 and req1 held high for 6 edges with we=1 and distinct addrs → grant order 0,1,0,1,0,1; mem_en high every cycle; each address written once per grant.
- FIXED_PRI=1, STARVE_LIM=4, both requesting continuously with port 0 re-requesting after every grant → port 1 is granted no later than its 5th arbitration edge, then starve_cnt returns to 0.
- Reset mid-flight: grant a load at E1, assert reset=0 at E2 → no rvalid0 at any later cycle; mem_en=0 after E2.
- DMEM_ARB_LOCK_EN defined, lock0=1 and req0=1 for 10 edges, req1=1 throughout → gnt0 high for 8 consecutive cycles, then gnt1 pulses; without the macro → gnt0 and gnt1 alternate.
